// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch stage.
// Widths here are the defaults; fetch_stage may be instantiated with other values.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    // Entry handed to decode: instruction tagged with the PC it was fetched from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, hence one bit more than the pointer.
    function automatic int credit_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush, used for both the PC tag queue and
// the instruction buffer. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    input  logic                           flush,
    output logic                           full,
    output logic                           empty,
    output logic [credit_cnt_w(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = credit_cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full & ~flush;
    assign w_do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; a slot is only read after a push has written it,
    // so clearing it would cost a reset net per bit for no observable effect.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues credit-limited requests at the current PC, tags
// in-order responses with their PC and presents them to decode; redirects drop in-flight work.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_q,
    output logic               pc_en,
    input  logic               flush,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr
);

    localparam int CNT_W   = credit_cnt_w(DEPTH);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_started;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W:0]       w_inflight;
    logic [CNT_W-1:0]     w_resp_dec;
    logic                 w_accept;
    logic                 w_resp_drop;
    logic                 w_resp_keep;
    logic                 w_id_fire;
    logic [ADDR_W-1:0]    w_tag_pc;
    logic [CNT_W-1:0]     w_tag_count;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic [ENTRY_W-1:0]   w_buf_head;
    logic [CNT_W-1:0]     w_buf_count;
    logic                 w_buf_full;
    logic                 w_buf_empty;
    logic                 w_unused;

    // Credits cover responses still owed (including ones that will be dropped)
    // plus entries waiting for decode, so a returning response always has a slot.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_buf_count};
    assign imem_req_valid = r_started & ~flush & (w_inflight < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign w_accept       = imem_req_valid & imem_req_ready;
    assign pc_en          = w_accept;

    assign w_resp_dec  = {{(CNT_W-1){1'b0}}, imem_resp_valid};
    assign w_resp_drop = imem_resp_valid & (r_drop_cnt != '0);
    assign w_resp_keep = imem_resp_valid & (r_drop_cnt == '0) & ~flush;

    // A handshake in a flush cycle is not a delivery; the flush empties the buffer anyway.
    assign id_valid  = ~w_buf_empty;
    assign w_id_fire = id_valid & id_ready & ~flush;
    assign id_pc     = id_valid ? w_buf_head[ENTRY_W-1 -: ADDR_W] : '0;
    assign id_instr  = id_valid ? w_buf_head[INSTR_W-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started     <= 1'b0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_started <= 1'b1;
            if (flush) begin
                // Everything still owed belongs to the old path, except a response
                // arriving right now, which is discarded here directly.
                r_outstanding <= r_outstanding - w_resp_dec;
                r_drop_cnt    <= r_outstanding - w_resp_dec;
            end else begin
                case ({w_accept, imem_resp_valid})
                    2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                    2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                    default: r_outstanding <= r_outstanding;
                endcase
                if (w_resp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_ONE;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_accept),
        .push_data (pc_q),
        .pop       (w_resp_keep),
        .pop_data  (w_tag_pc),
        .flush     (flush),
        .full      (w_tag_full),
        .empty     (w_tag_empty),
        .count     (w_tag_count)
    );

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_resp_keep),
        .push_data ({w_tag_pc, imem_resp_data}),
        .pop       (w_id_fire),
        .pop_data  (w_buf_head),
        .flush     (flush),
        .full      (w_buf_full),
        .empty     (w_buf_empty),
        .count     (w_buf_count)
    );

    // Status outputs only observed by the protocol checks below.
    assign w_unused = ^{w_tag_full, w_tag_empty, w_tag_count, w_buf_full};

    a_no_buf_overflow: assert property (@(posedge clk) disable iff (!reset)
        w_resp_keep |-> !w_buf_full);

    a_tag_available: assert property (@(posedge clk) disable iff (!reset)
        w_resp_keep |-> !w_tag_empty);

    a_credit_balance: assert property (@(posedge clk) disable iff (!reset)
        ({1'b0, w_tag_count} + {1'b0, r_drop_cnt}) == {1'b0, r_outstanding});

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a PC register, an in-order memory and an
// epoch-based scoreboard of what decode should see, stepped once per clock.
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int ADDR_W  = FETCH_ADDR_W;
    localparam int INSTR_W = FETCH_INSTR_W;
    localparam int DEPTH   = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
        int                epoch;
    } mem_req_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  pc_q = '0;
    logic               pc_en;
    logic               flush = 1'b0;
    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready = 1'b0;
    logic               imem_resp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_resp_data = '0;
    logic               id_valid;
    logic               id_ready = 1'b0;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;

    fetch_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_q            (pc_q),
        .pc_en           (pc_en),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
    );

    always #5 clk = ~clk;

    // Reference state: PC register, memory pipe, entries decode is owed, delivery log.
    logic [ADDR_W-1:0] pc_m;
    logic [ADDR_W-1:0] tgt = '0;
    bit                started_m;
    mem_req_t          mem_q[$];
    fetch_entry_t      exp_q[$];
    logic [ADDR_W-1:0] del_q[$];
    int                epoch = 0;
    int                cyc = 0;
    int                last_due = -1;
    int                lat_min = 1;
    int                lat_max = 1;
    bit                resp_now;

    bit                s_pc_en, s_req_valid, s_id_valid;
    logic [ADDR_W-1:0] s_id_pc, s_req_addr;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return INSTR_W'(32'h100 + a);
    endfunction

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        del_q.delete();
        pc_m      = '0;
        started_m = 1'b0;
        cyc       = 0;
        last_due  = -1;
        flush     = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
    endtask

    // Called at posedge+1; returns at the next posedge+1 after checking one cycle.
    task automatic step();
        bit       exp_rv, exp_acc;
        int       due;
        mem_req_t r;
        pc_q            = pc_m;
        resp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(mem_q[0].addr) : '0;
        @(negedge clk);
        exp_rv  = started_m && !flush && ((mem_q.size() + exp_q.size()) < DEPTH);
        exp_acc = exp_rv && imem_req_ready;
        s_pc_en = pc_en; s_req_valid = imem_req_valid; s_id_valid = id_valid;
        s_id_pc = id_pc; s_req_addr = imem_req_addr;

        n_checks++;
        if (imem_req_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
        n_checks++;
        if (pc_en !== exp_acc) begin
            n_fail++;
            $display("FAIL pc_en cyc=%0d got=%b exp=%b", cyc, pc_en, exp_acc);
        end
        n_checks++;
        if (imem_req_addr !== pc_m) begin
            n_fail++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc_m);
        end
        n_checks++;
        if (id_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            if (id_pc !== exp_q[0].pc || id_instr !== exp_q[0].instr) begin
                n_fail++;
                $display("FAIL id_entry cyc=%0d got=%h/%h exp=%h/%h",
                         cyc, id_pc, id_instr, exp_q[0].pc, exp_q[0].instr);
            end
        end

        // A redirect starts a new epoch; any response from an older epoch is stale.
        if (flush) begin
            exp_q.delete();
            epoch++;
            if (resp_now) void'(mem_q.pop_front());
        end else begin
            if (exp_q.size() != 0 && id_ready) begin
                del_q.push_back(exp_q[0].pc);
                void'(exp_q.pop_front());
            end
            if (resp_now) begin
                r = mem_q.pop_front();
                if (r.epoch == epoch) exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
            end
        end
        if (exp_acc) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
            pc_m = pc_m + 1'b1;
        end
        if (flush) pc_m = tgt;
        started_m = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // From posedge+1: hold reset over one edge, release at posedge+3.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        #2 reset = 1'b1;
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        for (int i = 0; i < 30 && (mem_q.size() != 0 || exp_q.size() != 0); i++) step();
        n_checks++;
        if (mem_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got=%0d/%0d exp=0/0", mem_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b%b%b exp=000", id_valid, imem_req_valid, pc_en);
        end
        n_checks++;
        if (id_pc !== '0 || id_instr !== '0) begin
            n_fail++;
            $display("FAIL reset_data got=%h/%h exp=0/0", id_pc, id_instr);
        end
        @(posedge clk);
        #1;
        #2 reset = 1'b1;
        imem_req_ready = 1'b1;
        step();
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_cycle_req got=%b exp=0", s_req_valid);
        end
    endtask

    task automatic test_streaming();
        int first_en = -1, first_v = -1;
        do_reset();
        imem_req_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (s_pc_en && first_en < 0) first_en = cyc - 1;
            if (s_id_valid && first_v < 0) first_v = cyc - 1;
        end
        n_checks++;
        if (first_en != 1) begin
            n_fail++;
            $display("FAIL stream_first_pc_en got=%0d exp=1", first_en);
        end
        n_checks++;
        if (first_v != 3) begin
            n_fail++;
            $display("FAIL stream_first_id_valid got=%0d exp=3", first_v);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (del_q.size() <= k || del_q[k] !== ADDR_W'(k)) begin
                n_fail++;
                $display("FAIL stream_order idx=%0d got=%h exp=%h", k,
                         (del_q.size() > k) ? del_q[k] : '1, k);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        do_reset();
        imem_req_ready = 1'b1; id_ready = 1'b0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_pc_en) n_acc++;
        end
        n_checks++;
        if (n_acc != 2 || s_req_valid !== 1'b0 || s_pc_en !== 1'b0 || pc_m !== ADDR_W'(2)) begin
            n_fail++;
            $display("FAIL bp_hold got=acc%0d/rv%b/en%b/pc%0d exp=acc2/rv0/en0/pc2",
                     n_acc, s_req_valid, s_pc_en, pc_m);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (del_q.size() < 5) begin
            n_fail++;
            $display("FAIL bp_progress got=%0d exp>=5", del_q.size());
        end
        for (int k = 0; k < del_q.size(); k++) begin
            if (del_q[k] !== ADDR_W'(k)) begin
                n_checks++;
                n_fail++;
                $display("FAIL bp_order idx=%0d got=%h exp=%h", k, del_q[k], k);
                break;
            end
        end
    endtask

    task automatic test_mem_stall();
        int mark, seen = 0;
        imem_req_ready = 1'b0; id_ready = 1'b1;
        flush = 1'b1; tgt = ADDR_W'(5);
        step();
        flush = 1'b0;
        mark = del_q.size();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (s_pc_en !== 1'b0 || s_req_addr !== ADDR_W'(5)) begin
                n_fail++;
                $display("FAIL stall_hold got=en%b/addr%h exp=en0/addr5", s_pc_en, s_req_addr);
            end
        end
        imem_req_ready = 1'b1;
        step();
        n_checks++;
        if (s_pc_en !== 1'b1 || s_req_addr !== ADDR_W'(5)) begin
            n_fail++;
            $display("FAIL stall_release got=en%b/addr%h exp=en1/addr5", s_pc_en, s_req_addr);
        end
        for (int i = 0; i < 12; i++) step();
        for (int k = mark; k < del_q.size(); k++) if (del_q[k] === ADDR_W'(5)) seen++;
        n_checks++;
        if (seen != 1 || del_q.size() <= mark || del_q[mark] !== ADDR_W'(5)) begin
            n_fail++;
            $display("FAIL stall_once got=%0d exp=1", seen);
        end
    endtask

    task automatic test_flush_outstanding();
        bit got = 0;
        drain();
        flush = 1'b1; tgt = ADDR_W'(6);
        step();
        flush = 1'b0;
        lat_min = 3; lat_max = 3; imem_req_ready = 1'b1;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) step();
        n_checks++;
        if (mem_q.size() != 2 || mem_q[0].addr !== ADDR_W'(6) || mem_q[1].addr !== ADDR_W'(7)) begin
            n_fail++;
            $display("FAIL fo_issue got=%0d reqs exp=6,7", mem_q.size());
        end
        flush = 1'b1; tgt = ADDR_W'(40);
        step();
        flush = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (s_id_valid) begin
                got = 1;
                n_checks++;
                if (s_id_pc !== ADDR_W'(40)) begin
                    n_fail++;
                    $display("FAIL fo_first_pc got=%h exp=28", s_id_pc);
                end
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL fo_timeout got=none exp=pc 40");
        end
    endtask

    task automatic test_flush_coincident();
        bit hit = 0, got = 0;
        drain();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (exp_q.size() >= 1 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                hit = 1; flush = 1'b1; id_ready = 1'b1; tgt = ADDR_W'(88);
            end
            step();
        end
        flush = 1'b0;
        n_checks++;
        if (!hit || s_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fc_setup got=hit%0d/v%b exp=hit1/v1", hit, s_id_valid);
        end
        step();
        n_checks++;
        if (s_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fc_cleared got=%b exp=0", s_id_valid);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (s_id_valid) begin
                got = 1;
                n_checks++;
                if (s_id_pc !== ADDR_W'(88)) begin
                    n_fail++;
                    $display("FAIL fc_first_pc got=%h exp=58", s_id_pc);
                end
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL fc_timeout got=none exp=pc 88");
        end
    endtask

    task automatic test_async_reset();
        int first_en = -1;
        do_reset();
        imem_req_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step();
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b%b%b exp=000", id_valid, imem_req_valid, pc_en);
        end
        model_reset();
        @(posedge clk);
        #1;
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_pc_en && first_en < 0) first_en = cyc - 1;
        end
        n_checks++;
        if (first_en != 1 || del_q.size() == 0 || del_q[0] !== '0) begin
            n_fail++;
            $display("FAIL async_restart got=en%0d/n%0d exp=en1/pc0", first_en, del_q.size());
        end
    endtask

    task automatic test_random();
        int base = del_q.size();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            id_ready       = ($urandom_range(3) != 0);
            imem_req_ready = ($urandom_range(3) != 0);
            flush          = ($urandom_range(19) == 0);
            tgt            = $urandom;
            step();
        end
        flush = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        n_checks++;
        if (del_q.size() - base < 100) begin
            n_fail++;
            $display("FAIL rand_progress got=%0d exp>=100", del_q.size() - base);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_mem_stall();
        test_flush_outstanding();
        test_flush_coincident();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name:
fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Consumes the current PC and issues word-addressed requests to instruction memory.
- Advances the PC only when a request is accepted.
- Tags responses with their PC and buffers them. Presents {pc, instr} to decode over a valid/ready handshake. Discards in-flight work on a control-flow redirect.

Parameters:
- ADDR_W, 32, PC / instruction-memory word-address width.
- INSTR_W, 32, instruction width.
- DEPTH, 2, maximum (outstanding requests + buffered instructions); power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; one clock domain only.
- pc_q  in  ADDR_W  current PC from the PC register.
- pc_en  out  1  PC advance enable (PC increments by 1 when high).
- flush  in  1  redirect; asserted in the same cycle the PC register's load_en is asserted.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch word address.
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_resp_data  in  INSTR_W  fetched instruction.
- id_valid  out  1  decode-side entry valid.
- id_ready  in  1  decode accepts entry.
- id_pc  out  ADDR_W  PC of presented instruction.
- id_instr  out  INSTR_W  presented instruction.

Behaviour:
- Reset (reset low, asynchronous):
  - outstanding=0, drop_cnt=0, both FIFOs empty.
  - id_valid=0, id_pc=0, id_instr=0, imem_req_valid=0, pc_en=0.
  - The started flag clears. It sets on the first clk edge after reset deasserts, so the first request is no earlier than cycle 1 after release.
- Request rule: imem_req_valid = started & !flush & (outstanding + buffered < DEPTH).
  - imem_req_addr = pc_q, combinational.
  - Accept = imem_req_valid & imem_req_ready.
  - pc_en = accept, exactly one cycle per accepted request. Never asserted in a flush cycle; load_en has priority in the PC.
  - On accept, pc_q is pushed to the tag FIFO (depth DEPTH) and outstanding increments.
- Response rule: each imem_resp_valid decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Else: the tag FIFO is popped, and {tag, data} is pushed into the instruction buffer (depth DEPTH).
  - The credit rule guarantees the buffer is never full on push. Overflow is an assertion failure.
- Output: id_valid = buffer non-empty; id_pc and id_instr come from the buffer head. The buffer pops on id_valid & id_ready.
  - Minimum latency: request accepted cycle N, response N+1, id_valid N+2.
- Simultaneous accept and response in one cycle: outstanding is unchanged (+1−1).
- Simultaneous buffer push and pop: occupancy is unchanged. With a full buffer, a pop frees a credit only in the next cycle (no same-cycle credit bypass).
- Flush (synchronous, highest priority):
  - Buffer and tag FIFO are emptied.
  - id_valid=0 from the next cycle. A head handshake in the flush cycle does not count as delivered; decode must not commit it.
  - drop_cnt := outstanding − (imem_resp_valid ? 1 : 0). Any response arriving in the flush cycle is discarded.
  - No request is issued in the flush cycle. Requests resume the next cycle from the new PC, even while drop_cnt>0.
  - Because ordering is preserved, the dropped responses are exactly the oldest drop_cnt responses.
- Back-to-back flushes: drop_cnt is recomputed from the current outstanding each time.
- Width rules:
  - outstanding and buffered are $clog2(DEPTH)+1 bits and saturate at no point; the credit rule prevents exceeding DEPTH.
  - PC wrap-around is the PC register's concern; addresses pass through unmodified.
- Reset mid-operation: asynchronous clear as above. Any memory response arriving after release is not expected; the memory shares the reset.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W, INSTR_W defaults.
  - fetch_entry_t = {pc, instr}.
  - Credit-counter width function.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated twice: tag FIFO (WIDTH=ADDR_W) and instruction buffer (WIDTH=ADDR_W+INSTR_W).

Test Plan:
- Streaming: memory always ready, 1-cycle latency, id_ready=1, mem[k]=0x100+k.
  - pc_en is high from cycle 1.
  - Decode receives (0,0x100), (1,0x101), (2,0x102), (3,0x103) on consecutive cycles from cycle 3.
- Backpressure: id_ready=0 from reset.
  - After 2 requests (PC 0,1) imem_req_valid=0 and pc_en=0; PC holds at 2.
  - Raise id_ready: entries 0,1,2… are delivered in order with no loss or duplication.
- Memory stall: imem_req_ready=0 for 3 cycles with pc_q=5.
  - pc_en=0 and imem_req_addr=5 throughout.
  - One request for 5 on release; decode sees pc 5 exactly once.
- Flush with 2 outstanding (PCs 6,7, latency 3), flush with PC loaded to 40.
  - Responses for 6 and 7 are dropped.
  - id_valid stays 0 until the response for 40; the first delivery is id_pc=40.
- Flush coincident with a response and with id_valid & id_ready.
  - Head entry, the arriving response, and all buffered entries are discarded.
  - drop_cnt = outstanding−1; the next delivered pc equals the redirect target.
- Async reset asserted mid-stream between clock edges.
  - id_valid, imem_req_valid and pc_en go 0 immediately.
  - After release, fetch restarts at pc 0 with counters zero.
